axi_wr_slave_sram: RTL and testbench
====================================

Name: axi_wr_slave_sram

Overview:
AXI write-channel responder at the slave end of the write interconnect.
- Accepts one AW burst at a time from the interconnect (8-bit slave-side ID) and absorbs W beats.
- Drives a single-port SRAM macro write interface for every accepted beat.
- Returns one B response per burst.
- Instantiated once per memory slave (IM/DM wrappers), next to the read-side responder.

Parameters:
- MEM_AW, 14, SRAM word-address width (word = 32 bits).
- BASE_ADDR, 32'h0001_0000, slave base address; used only under the optional feature.
- SLV_SIZE_LOG2, 16, log2 of slave region bytes; used only under the optional feature.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  async active-low reset
- AWID  in  8  slave-side write ID (AXI_IDS_BITS)
- AWADDR  in  32  byte start address
- AWLEN  in  4  beats-1
- AWSIZE  in  3  must be 3'b010
- AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP
- AWVALID  in  1
- AWREADY  out  1
- WDATA  in  32
- WSTRB  in  4  byte enables
- WLAST  in  1
- WVALID  in  1
- WREADY  out  1
- BID  out  8
- BRESP  out  2
- BVALID  out  1
- BREADY  in  1
- SRAM_CEB  out  1  chip enable, active low
- SRAM_WEB  out  4  per-byte write enable, active low
- SRAM_A  out  MEM_AW  word address
- SRAM_DI  out  32  write data

Behaviour:
- Reset: ARESETn, asynchronous, active-low; clock ACLK. All state registers clear asynchronously; state=IDLE; id/addr/len/count regs = 0.
- Output values at reset: AWREADY=1 (IDLE), WREADY=0, BVALID=0, BID=0, BRESP=0, SRAM_CEB=1, SRAM_WEB=4'hF, SRAM_A=0, SRAM_DI=0.
- FSM states: IDLE, DATA, RESP. All outputs are decoded from state plus registers.
- IDLE:
  - AWREADY=1.
  - On AWVALID&&AWREADY: latch AWID, AWADDR[MEM_AW+1:2], AWLEN, AWBURST; clear beat count; go to DATA next cycle.
  - W beats presented in IDLE are not accepted (WREADY=0).
- DATA:
  - WREADY=1, AWREADY=0.
  - On each WVALID&&WREADY, in the same cycle: SRAM_CEB=0, SRAM_WEB=~WSTRB, SRAM_A=addr_r, SRAM_DI=WDATA.
  - Without a handshake: CEB=1, WEB=4'hF.
  - WSTRB=0 beat: CEB=0, WEB=4'hF (no byte written), still counted.
- Address update after each beat:
  - INCR: addr_r+1, wrapping modulo 2^MEM_AW.
  - FIXED: unchanged.
  - WRAP: treated as INCR unless the optional feature is enabled.
- Beat count increments per beat. Burst ends on the handshake where WLAST=1, or count==len_r, whichever comes first. Next state is RESP.
- RESP:
  - BVALID=1, BID=id_r, BRESP=resp_r (00 OKAY by default).
  - Hold all B signals stable until BREADY. On BVALID&&BREADY go to IDLE next cycle; AWREADY returns the cycle after.
  - BREADY already high on RESP entry: one-cycle BVALID pulse.
  - No new AW is accepted while in DATA or RESP (single outstanding transaction).
- Throughput: min burst of N beats = 1 (AW) + N (W) + 1 (B) cycles.
- Reset mid-burst: FSM returns to IDLE immediately. Partial SRAM writes already performed remain. No B is issued.

Optional Feature:
- Macro AXI_WR_ERR_CHECK_EN.
- When defined, a transaction gets resp_r=2'b10 (SLVERR) if any of these hold:
  - AWADDR[31:SLV_SIZE_LOG2] != BASE_ADDR[31:SLV_SIZE_LOG2];
  - AWSIZE != 3'b010;
  - AWBURST == WRAP or 2'b11;
  - WLAST arrives with count != len_r.
- Address, size and burst errors are flagged at AW accept. For error transactions, all W beats are still accepted but SRAM_CEB stays 1.
- WLAST-mismatch bursts keep the writes already performed and respond SLVERR.
- When the macro is undefined, BRESP is always OKAY and no checks are synthesized.

Decomposition:
- Shared package axi_pkg holds:
  - state enum {IDLE, DATA, RESP};
  - resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - burst constants BURST_FIXED/INCR/WRAP.
- Bit widths come from the existing AXI define header.
- One natural sub-module, axi_wr_addr_gen: latched address, burst type, beat counter and last-beat detect. The FSM and SRAM drive stay in the top.

Test Plan:
- Single write: AWADDR=0x0000_0010, LEN=0, INCR, WDATA=0xDEADBEEF, WSTRB=F. Expect SRAM_A=4, WEB=0, one CEB pulse; then BVALID with BID=AWID=0x13 and BRESP=00.
- INCR burst: LEN=3 from 0x100 with WVALID gaps. Expect writes to A=0x40..0x43 only on handshake cycles, and B only after the 4th beat.
- Byte strobes: WSTRB=4'b0101 → WEB=4'b1010. WSTRB=0 → CEB=0, WEB=F.
- B backpressure: BREADY held low 5 cycles. BVALID, BID and BRESP stay stable, AWVALID is ignored (AWREADY=0), and IDLE is reached the cycle after BREADY.
- Wrap-around: AWADDR at word 2^MEM_AW-1, LEN=1. Second beat writes A=0.
- With AXI_WR_ERR_CHECK_EN:
  - AWADDR=0x2000_0000 → no CEB, BRESP=10.
  - Early WLAST on LEN=3 at beat 2 → BRESP=10.
  - Reset asserted mid-burst → AWREADY=1, BVALID=0 after release.

Source files
------------

// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI write-side types, widths and encodings
package axi_pkg;
  localparam int ID_W   = 8;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int LEN_W  = 4;
  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [2:0] SIZE_WORD   = 3'b010;
endpackage

// File: rtl/axi_wr_addr_gen.sv
// axi_wr_addr_gen: latched burst word address, beat counter and last-beat detect
module axi_wr_addr_gen
  import axi_pkg::*;
#(
  parameter int MEM_AW = 14
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              load,
  input  logic              beat,
  input  logic [MEM_AW-1:0] start_addr,
  input  logic [LEN_W-1:0]  start_len,
  input  logic [1:0]        start_burst,
  output logic [MEM_AW-1:0] addr,
  output logic              last
);
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] count;
  logic [1:0]       burst_r;
  // capture on AW accept, advance on every accepted W beat; non-FIXED bursts increment and wrap at the top of the SRAM
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      addr    <= '0;
      len_r   <= '0;
      count   <= '0;
      burst_r <= BURST_FIXED;
    end else if (load) begin
      addr    <= start_addr;
      len_r   <= start_len;
      count   <= '0;
      burst_r <= start_burst;
    end else if (beat) begin
      addr  <= (burst_r == BURST_FIXED) ? addr : addr + 1'b1;
      count <= count + 1'b1;
    end
  end
  assign last = (count == len_r);
endmodule

// File: rtl/axi_wr_slave_sram.sv
// axi_wr_slave_sram: AXI write responder driving a single-port SRAM (optional AXI_WR_ERR_CHECK_EN adds SLVERR checks)
module axi_wr_slave_sram
  import axi_pkg::*;
#(
  parameter int          MEM_AW        = 14,
  parameter logic [31:0] BASE_ADDR     = 32'h0001_0000,
  parameter int          SLV_SIZE_LOG2 = 16
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ID_W-1:0]   AWID,
  input  logic [31:0]       AWADDR,
  input  logic [LEN_W-1:0]  AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [STRB_W-1:0] WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  output logic              SRAM_CEB,
  output logic [STRB_W-1:0] SRAM_WEB,
  output logic [MEM_AW-1:0] SRAM_A,
  output logic [DATA_W-1:0] SRAM_DI
);
  state_t            state, state_nx;
  logic [ID_W-1:0]   id_r;
  logic [1:0]        resp_r;
  logic [MEM_AW-1:0] addr_r;
  logic              last_beat, aw_hs, w_hs, burst_end, wr_en, unused_ok;
  assign aw_hs     = AWVALID & (state == IDLE);
  assign w_hs      = WVALID & (state == DATA);
  assign burst_end = w_hs & (WLAST | last_beat);
  assign unused_ok = ^{AWADDR[31:MEM_AW+2], AWADDR[1:0], AWSIZE, BASE_ADDR, 32'(SLV_SIZE_LOG2)};
  axi_wr_addr_gen #(.MEM_AW(MEM_AW)) u_addr_gen (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .load        (aw_hs),
    .beat        (w_hs),
    .start_addr  (AWADDR[MEM_AW+1:2]),
    .start_len   (AWLEN),
    .start_burst (AWBURST),
    .addr        (addr_r),
    .last        (last_beat)
  );
`ifdef AXI_WR_ERR_CHECK_EN
  logic aw_err;
  assign aw_err = (AWADDR[31:SLV_SIZE_LOG2] != BASE_ADDR[31:SLV_SIZE_LOG2]) | (AWSIZE != SIZE_WORD) |
                  (AWBURST == BURST_WRAP) | (AWBURST == 2'b11);
  assign wr_en  = w_hs & (resp_r == RESP_OKAY);
  // response status: decided at AW accept, downgraded when WLAST disagrees with the burst length
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) resp_r <= RESP_OKAY;
    else if (aw_hs) resp_r <= aw_err ? RESP_SLVERR : RESP_OKAY;
    else if (burst_end & WLAST & ~last_beat) resp_r <= RESP_SLVERR;
  end
`else
  assign wr_en  = w_hs;
  assign resp_r = RESP_OKAY;
`endif
  // transaction ID held from AW accept until the B handshake
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) id_r <= '0;
    else if (aw_hs) id_r <= AWID;
  end
  // FSM state register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= IDLE;
    else state <= state_nx;
  end
  // FSM next state: one outstanding burst, AW -> W beats -> B
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = aw_hs ? DATA : IDLE;
      DATA:    state_nx = burst_end ? RESP : DATA;
      RESP:    state_nx = BREADY ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  // outputs decoded from state and registers; SRAM strobes only on an accepted beat
  always_comb begin
    AWREADY  = (state == IDLE);
    WREADY   = (state == DATA);
    BVALID   = (state == RESP);
    BID      = id_r;
    BRESP    = resp_r;
    SRAM_CEB = ~wr_en;
    SRAM_WEB = wr_en ? ~WSTRB : 4'hF;
    SRAM_A   = addr_r;
    SRAM_DI  = wr_en ? WDATA : '0;
  end
endmodule

// File: tb/tb_axi_wr_slave_sram.sv
// tb_axi_wr_slave_sram: scoreboard bench for the AXI write responder (default build)
module tb_axi_wr_slave_sram;
  localparam int AW = 14;
  logic          ACLK = 0, ARESETn;
  logic [7:0]    AWID;
  logic [31:0]   AWADDR;
  logic [3:0]    AWLEN;
  logic [2:0]    AWSIZE;
  logic [1:0]    AWBURST;
  logic          AWVALID, AWREADY;
  logic [31:0]   WDATA;
  logic [3:0]    WSTRB;
  logic          WLAST, WVALID, WREADY;
  logic [7:0]    BID;
  logic [1:0]    BRESP;
  logic          BVALID, BREADY;
  logic          SRAM_CEB;
  logic [3:0]    SRAM_WEB;
  logic [AW-1:0] SRAM_A;
  logic [31:0]   SRAM_DI;

  always #5 ACLK = ~ACLK;

  axi_wr_slave_sram #(.MEM_AW(AW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .SRAM_CEB(SRAM_CEB), .SRAM_WEB(SRAM_WEB), .SRAM_A(SRAM_A), .SRAM_DI(SRAM_DI)
  );

  typedef struct {logic [AW-1:0] a; logic [3:0] web; logic [31:0] di;} wr_t;
  typedef struct {logic [7:0] id; logic [1:0] resp;} b_t;
  wr_t wq[$];
  b_t  bq[$];
  int  pass_n = 0, tot_n = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  logic       pbv, pbr;
  logic [7:0] pbid;
  logic [1:0] pbresp;

  // monitor: every SRAM strobe and every B handshake is matched against the scoreboard
  always @(negedge ACLK) begin
    if (ARESETn) begin
      if (!SRAM_CEB) begin
        if (wq.size() == 0) chk("unexpected_write", {50'd0, SRAM_A}, 64'hFFFF);
        else begin
          chk("sram_a", SRAM_A, wq[0].a);
          chk("sram_web", SRAM_WEB, wq[0].web);
          chk("sram_di", SRAM_DI, wq[0].di);
          void'(wq.pop_front());
        end
      end else if (SRAM_WEB !== 4'hF) chk("idle_web", SRAM_WEB, 4'hF);
      if (BVALID && pbv && !pbr) begin
        chk("bid_stable", BID, pbid);
        chk("bresp_stable", BRESP, pbresp);
      end
      if (BVALID && BREADY) begin
        if (bq.size() == 0) chk("unexpected_b", BID, 9'h100);
        else begin
          chk("bid", BID, bq[0].id);
          chk("bresp", BRESP, bq[0].resp);
          void'(bq.pop_front());
        end
      end
      pbv <= BVALID; pbr <= BREADY; pbid <= BID; pbresp <= BRESP;
    end else pbv <= 1'b0;
  end

  // one burst: bdel<0 keeps BREADY high before BVALID; no_b leaves the burst unfinished
  task automatic do_burst(input logic [7:0] id, input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input int nbeats, input bit wlast_final, input int strb_sel, input int gap_max,
                          input int bdel, input bit no_b, input logic [31:0] dfirst);
    logic [AW-1:0] w0, wa;
    logic [31:0]   d;
    logic [3:0]    s;
    int            t;
    bit            hs;
    w0 = addr[AW+1:2];
    AWVALID = 1; AWID = id; AWADDR = addr; AWLEN = len[3:0]; AWSIZE = 3'b010; AWBURST = burst;
    t = 0; hs = 0;
    while (!hs && t < 100) begin @(negedge ACLK); hs = AWREADY; @(posedge ACLK); #1; t++; end
    if (!hs) chk("aw_timeout", 0, 1);
    AWVALID = 0;
    if (!no_b) bq.push_back('{id, 2'b00});
    if (bdel < 0) BREADY = 1;
    for (int i = 0; i < nbeats; i++) begin
      repeat ($urandom_range(0, gap_max)) begin @(posedge ACLK); #1; end
      d  = (i == 0 && dfirst != 0) ? dfirst : $urandom;
      s  = (strb_sel < 0) ? 4'($urandom) : strb_sel[3:0];
      wa = (burst == 2'b00) ? w0 : w0 + AW'(i);
      WVALID = 1; WDATA = d; WSTRB = s; WLAST = (i == nbeats - 1) && wlast_final;
      wq.push_back('{wa, ~s, d});
      t = 0; hs = 0;
      while (!hs && t < 100) begin @(negedge ACLK); hs = WREADY; @(posedge ACLK); #1; t++; end
      if (!hs) chk("w_timeout", 0, 1);
      WVALID = 0; WLAST = 0;
    end
    if (no_b) return;
    t = 0; hs = 0;
    while (!hs && t < 100) begin
      @(negedge ACLK); hs = BVALID;
      if (!hs) begin @(posedge ACLK); #1; end
      t++;
    end
    if (!hs) chk("b_timeout", 0, 1);
    if (bdel >= 0) begin
      repeat (bdel) begin
        @(posedge ACLK); #1; AWVALID = 1; AWADDR = $urandom;
        @(negedge ACLK);
        chk("awready_in_resp", AWREADY, 0);
        chk("bvalid_held", BVALID, 1);
      end
      @(posedge ACLK); #1; AWVALID = 0; BREADY = 1;
      @(negedge ACLK);
      chk("bvalid_at_hs", BVALID, 1);
    end
    @(posedge ACLK); #1; BREADY = 0;
    @(negedge ACLK);
    chk("awready_after_b", AWREADY, 1);
    chk("bvalid_after_b", BVALID, 0);
    @(posedge ACLK); #1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int len, nb, md;
    ARESETn = 0; AWVALID = 0; AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 3'b010; AWBURST = 2'b01;
    WVALID = 0; WDATA = 0; WSTRB = 0; WLAST = 0; BREADY = 0;
    repeat (2) @(negedge ACLK);
    chk("rst_awready", AWREADY, 1);
    chk("rst_wready", WREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_bid", BID, 0);
    chk("rst_bresp", BRESP, 0);
    chk("rst_ceb", SRAM_CEB, 1);
    chk("rst_web", SRAM_WEB, 4'hF);
    chk("rst_a", SRAM_A, 0);
    chk("rst_di", SRAM_DI, 0);
    @(posedge ACLK); #1; ARESETn = 1;
    @(posedge ACLK); #1; WVALID = 1; WSTRB = 4'hF; WDATA = 32'h1234_5678;
    @(negedge ACLK);
    chk("wready_idle", WREADY, 0);
    @(posedge ACLK); #1; WVALID = 0;
    do_burst(8'h13, 32'h0000_0010, 0, 2'b01, 1, 1, 15, 0, 0, 0, 32'hDEAD_BEEF);
    do_burst(8'h22, 32'h0000_0100, 3, 2'b01, 4, 1, 15, 3, 1, 0, 0);
    do_burst(8'h31, 32'h0000_0400, 0, 2'b01, 1, 1, 5, 0, 0, 0, 0);
    do_burst(8'h32, 32'h0000_0404, 0, 2'b01, 1, 1, 0, 0, 0, 0, 0);
    do_burst(8'h44, 32'h0000_0800, 1, 2'b01, 2, 1, -1, 0, 5, 0, 0);
    do_burst(8'h55, 32'h0000_FFFC, 1, 2'b01, 2, 1, -1, 1, 0, 0, 0);
    do_burst(8'h66, 32'h0000_0200, 2, 2'b00, 3, 1, -1, 1, -1, 0, 0);
    do_burst(8'h77, 32'h0000_0300, 3, 2'b01, 4, 0, -1, 0, 1, 0, 0);
    do_burst(8'h88, 32'h0000_0500, 3, 2'b01, 2, 1, -1, 0, 0, 0, 0);
    do_burst(8'h99, 32'h0000_0600, 3, 2'b01, 2, 0, -1, 0, 0, 1, 0);
    ARESETn = 0;
    @(negedge ACLK);
    chk("midrst_awready", AWREADY, 1);
    chk("midrst_wready", WREADY, 0);
    @(posedge ACLK); #1; ARESETn = 1;
    @(negedge ACLK);
    chk("postrst_awready", AWREADY, 1);
    chk("postrst_bvalid", BVALID, 0);
    @(posedge ACLK); #1;
    for (int k = 0; k < 40; k++) begin
      len = $urandom_range(0, 15);
      md  = $urandom_range(0, 3);
      nb  = (md == 0) ? $urandom_range(1, len + 1) : len + 1;
      do_burst(8'($urandom), $urandom, len, 2'($urandom_range(0, 2)), nb, md != 1, -1, 2,
               $urandom_range(0, 4) - 1, 0, 0);
    end
    repeat (3) @(negedge ACLK);
    chk("wq_empty", wq.size(), 0);
    chk("bq_empty", bq.size(), 0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
